// File: rtl/cycle_window_pkg.sv
`default_nettype none
// ============================================================================
// Module : cycle_window_pkg
// Brief  : Shared constants and channel-state type for the cycle window counter.
// Rev    : 1.0  initial release
// ============================================================================
package cycle_window_pkg;

    localparam int CNT_W_DEF = 5;
    localparam int TC_DEF    = 24;
    // Widest counter the channel-state struct can carry.
    localparam int CNT_W_MAX = 16;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef struct packed {
        logic [CNT_W_MAX-1:0] count;
        logic                 finished;
        logic                 overrun;
        logic                 halted;
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/cycle_window_channel.sv
`default_nettype none
// ============================================================================
// Module : cycle_window_channel
// Brief  : One counter channel: count, sticky finished/overrun, one-shot halt.
//          Overrun tracking is built only when CYCLE_WINDOW_OVERRUN_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module cycle_window_channel
    import cycle_window_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             increment_i,
    input  logic             restart_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] term_count_i,
    input  logic             oneshot_i,
    output logic [CNT_W-1:0] count_o,
    output logic             finished_o,
    output logic             overrun_o
);

    logic [CNT_W-1:0]     count_q, count_d;
    logic                 finished_q, finished_d;
    logic                 halted_q, halted_d;
`ifdef CYCLE_WINDOW_OVERRUN_EN
    logic                 overrun_q, overrun_d;
`endif

    chan_state_t          cur;
    logic [CNT_W_MAX-1:0] term_ext;
    logic                 inc_ok;
    logic                 term_evt;

    always_comb begin
        cur          = '0;
        cur.count    = CNT_W_MAX'(count_q);
        cur.finished = finished_q;
        cur.halted   = halted_q;
`ifdef CYCLE_WINDOW_OVERRUN_EN
        cur.overrun  = overrun_q;
`else
        cur.overrun  = 1'b0;
`endif
    end

    assign term_ext = CNT_W_MAX'(term_count_i);
    // Restart outranks increment, so a coincident pulse is dropped here.
    assign inc_ok   = increment_i & enable_i & ~cur.halted & ~restart_i;
    assign term_evt = inc_ok & (cur.count >= term_ext);

    always_comb begin
        count_d    = count_q;
        halted_d   = cur.halted;
        finished_d = cur.finished;
        if (restart_i) begin
            count_d  = '0;
            halted_d = 1'b0;
        end else if (inc_ok) begin
            if (term_evt) begin
                count_d = '0;
                if (oneshot_i == MODE_ONESHOT) begin
                    halted_d = 1'b1;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        // A terminal event wins over clear so that no event is lost.
        if (term_evt) begin
            finished_d = 1'b1;
        end else if (clear_i) begin
            finished_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            finished_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            finished_q <= finished_d;
            halted_q   <= halted_d;
        end
    end

`ifdef CYCLE_WINDOW_OVERRUN_EN
    always_comb begin
        overrun_d = cur.overrun;
        if (clear_i) begin
            overrun_d = 1'b0;
        end else if (term_evt && cur.finished) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end
`endif

    assign count_o    = count_q;
    assign finished_o = finished_q;
    assign overrun_o  = cur.overrun;

endmodule
`default_nettype wire

// File: rtl/cycle_window_counter.sv
`default_nettype none
// ============================================================================
// Module : cycle_window_counter
// Brief  : Multi-channel line-cycle counter with programmable terminal count.
//          Optional overrun tracking: define CYCLE_WINDOW_OVERRUN_EN.
// Rev    : 1.0  initial release
// ============================================================================
module cycle_window_counter
    import cycle_window_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TC_RST = TC_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [NUM_CH-1:0]       increment_i,
    input  logic [NUM_CH-1:0]       restart_i,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic [CNT_W-1:0]        term_count_i,
    input  logic                    oneshot_i,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       finished_o,
    output logic [NUM_CH-1:0]       overrun_o,
    output logic                    any_finished_o
);

    // TC_RST is the host's power-on terminal count; it must fit the counter.
    if (NUM_CH < 1 || NUM_CH > 8 || CNT_W < 1 || CNT_W > CNT_W_MAX ||
        TC_RST < 0 || TC_RST > (1 << CNT_W) - 1) begin : g_bad_param
        $error("cycle_window_counter: illegal NUM_CH/CNT_W/TC_RST");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cycle_window_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .enable_i     (enable_i),
            .increment_i  (increment_i[c]),
            .restart_i    (restart_i[c]),
            .clear_i      (clear_i[c]),
            .term_count_i (term_count_i),
            .oneshot_i    (oneshot_i),
            .count_o      (count_o[c*CNT_W +: CNT_W]),
            .finished_o   (finished_o[c]),
            .overrun_o    (overrun_o[c])
        );
    end

    assign any_finished_o = |finished_o;

endmodule
`default_nettype wire

// File: tb/tb_cycle_window_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_cycle_window_counter
// Brief  : Self-checking bench with a cycle-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cycle_window_counter;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 5;
`ifdef CYCLE_WINDOW_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    enable_i;
    logic [NUM_CH-1:0]       increment_i;
    logic [NUM_CH-1:0]       restart_i;
    logic [NUM_CH-1:0]       clear_i;
    logic [CNT_W-1:0]        term_count_i;
    logic                    oneshot_i;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic [NUM_CH-1:0]       finished_o;
    logic [NUM_CH-1:0]       overrun_o;
    logic                    any_finished_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int cnt;
        bit fin;
        bit ovr;
        bit halt;
    } mstate_t;

    mstate_t m [NUM_CH];

    always #5 clk_i = ~clk_i;

    cycle_window_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .TC_RST (24)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .increment_i    (increment_i),
        .restart_i      (restart_i),
        .clear_i        (clear_i),
        .term_count_i   (term_count_i),
        .oneshot_i      (oneshot_i),
        .count_o        (count_o),
        .finished_o     (finished_o),
        .overrun_o      (overrun_o),
        .any_finished_o (any_finished_o)
    );

    function automatic mstate_t step(mstate_t s, bit en, bit inc, bit rs, bit clr,
                                     int term, bit one);
        mstate_t n  = s;
        bit      ev = 1'b0;
        if (rs) begin
            n.cnt  = 0;
            n.halt = 1'b0;
        end else if (inc && en && !s.halt) begin
            if (s.cnt >= term) begin
                ev    = 1'b1;
                n.cnt = 0;
                if (one) n.halt = 1'b1;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        if (clr) begin
            n.fin = ev;
            n.ovr = 1'b0;
        end else if (ev) begin
            if (s.fin && OVR_EN) n.ovr = 1'b1;
            n.fin = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i)
                m[c] <= '{0, 1'b0, 1'b0, 1'b0};
            else
                m[c] <= step(m[c], enable_i, increment_i[c], restart_i[c], clear_i[c],
                             int'(term_count_i), oneshot_i);
        end
    end

    task automatic check(input string name, input int ch, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d at %0t: got %0d, expected %0d", name, ch, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                check("model_count", c, 32'(count_o[c*CNT_W +: CNT_W]), 32'(m[c].cnt));
                check("model_finished", c, 32'(finished_o[c]), 32'(m[c].fin));
                check("model_overrun", c, 32'(overrun_o[c]), 32'(m[c].ovr));
            end
            check("model_any_finished", 0, 32'(any_finished_o),
                  32'(m[0].fin | m[1].fin));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        increment_i = mask;
        tick();
        increment_i = '0;
        tick();
    endtask

    task automatic lit(input string name, input int ch, input int cnt, input bit fin);
        check({name, "_count"}, ch, 32'(count_o[ch*CNT_W +: CNT_W]), 32'(cnt));
        check({name, "_finished"}, ch, 32'(finished_o[ch]), 32'(fin));
    endtask

    initial begin
        int exp_cnt [6];
        exp_cnt = '{1, 2, 3, 0, 0, 0};

        rst_i        = 1'b1;
        enable_i     = 1'b0;
        increment_i  = '0;
        restart_i    = '0;
        clear_i      = '0;
        term_count_i = 5'd24;
        oneshot_i    = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        check("reset_count", 0, 32'(count_o), 32'd0);
        check("reset_finished", 0, 32'(finished_o), 32'd0);
        check("reset_overrun", 0, 32'(overrun_o), 32'd0);
        check("reset_any", 0, 32'(any_finished_o), 32'd0);

        // Basic wrap at 24
        enable_i = 1'b1;
        for (int i = 0; i < 24; i++) pulse(2'b01);
        lit("wrap_at24", 0, 24, 1'b0);
        pulse(2'b01);
        lit("wrap_25th", 0, 0, 1'b1);
        lit("wrap_ch1", 1, 0, 1'b0);
        check("wrap_any", 0, 32'(any_finished_o), 32'd1);

        // One-shot with term 3
        clear_i   = 2'b01;
        restart_i = 2'b01;
        tick();
        clear_i   = '0;
        restart_i = '0;
        term_count_i = 5'd3;
        oneshot_i    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse(2'b01);
            lit("oneshot", 0, exp_cnt[i], i >= 3);
        end
        restart_i = 2'b01;
        tick();
        restart_i = '0;
        pulse(2'b01);
        lit("oneshot_restart", 0, 1, 1'b1);
        oneshot_i = 1'b0;

        // Clear colliding with a terminal event
        term_count_i = 5'd1;
        increment_i  = 2'b01;
        clear_i      = 2'b01;
        tick();
        increment_i  = '0;
        clear_i      = '0;
        tick();
        lit("clr_collide", 0, 0, 1'b1);
        check("clr_collide_ovr", 0, 32'(overrun_o[0]), 32'd0);
        pulse(2'b01);
        pulse(2'b01);
        lit("second_evt", 0, 0, 1'b1);
        check("second_evt_ovr", 0, 32'(overrun_o[0]), 32'(OVR_EN));

        // Terminal count lowered mid-run, then term 0
        restart_i = 2'b01;
        clear_i   = 2'b01;
        tick();
        restart_i = '0;
        clear_i   = '0;
        term_count_i = 5'd31;
        increment_i  = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        increment_i = '0;
        tick();
        lit("run_to10", 0, 10, 1'b0);
        term_count_i = 5'd4;
        pulse(2'b01);
        lit("term_lowered", 0, 0, 1'b1);
        term_count_i = 5'd0;
        pulse(2'b01);
        pulse(2'b01);
        lit("term0", 0, 0, 1'b1);
        pulse(2'b11);
        check("both_fin", 0, 32'(finished_o), 32'd3);
        check("both_cnt", 0, 32'(count_o), 32'd0);

        // Priority: restart over increment, reset over all, enable gate
        clear_i   = 2'b11;
        restart_i = 2'b11;
        tick();
        clear_i   = '0;
        restart_i = '0;
        term_count_i = 5'd31;
        for (int i = 0; i < 7; i++) pulse(2'b01);
        lit("pre_restart", 0, 7, 1'b0);
        increment_i = 2'b01;
        restart_i   = 2'b01;
        tick();
        increment_i = '0;
        restart_i   = '0;
        lit("restart_wins", 0, 0, 1'b0);
        term_count_i = 5'd0;
        pulse(2'b01);
        pulse(2'b01);
        term_count_i = 5'd31;
        restart_i = 2'b01;
        tick();
        restart_i = '0;
        for (int i = 0; i < 12; i++) pulse(2'b01);
        lit("pre_reset", 0, 12, 1'b1);
        check("pre_reset_ovr", 0, 32'(overrun_o[0]), 32'(OVR_EN));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrun_reset_count", 0, 32'(count_o), 32'd0);
        check("midrun_reset_fin", 0, 32'(finished_o), 32'd0);
        check("midrun_reset_ovr", 0, 32'(overrun_o), 32'd0);
        check("midrun_reset_any", 0, 32'(any_finished_o), 32'd0);
        for (int i = 0; i < 3; i++) pulse(2'b01);
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) pulse(2'b11);
        lit("enable_low", 0, 3, 1'b0);
        lit("enable_low", 1, 0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
